// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencing and hazard control for a Y86-style pipeline.
//
// Ports
//   clock, reset           single clock, synchronous active-high reset
//   f_icode..f_mem_error   fetch-stage decode of the current pc_val
//   d_srcA, d_srcB         decode-stage source register IDs (4'hF = none)
//   e_icode, e_dstM        execute-stage icode and load destination
//   e_cnd, e_valA          branch condition and fall-through PC
//   w_icode, w_valM, w_exc write-back icode, memory value, exception commit
//   pc_val                 registered PC presented to fetch
//   f_stall, d_stall,
//   d_bubble, e_bubble     pipeline-register controls (combinational)
//   stat                   registered status: 1=AOK 2=HLT 3=ADR 4=INS
//   halted                 processor has stopped
//   mispredict_cnt,
//   stall_cnt              performance counters
//
// Optional feature macro: FETCH_SEQ_PERF_EN enables the saturating
// performance counters; when it is undefined both read as 0 and no counter
// flops are built.

module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  f_icode,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        f_valid,
  input  logic        f_mem_error,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  e_icode,
  input  logic [3:0]  e_dstM,
  input  logic        e_cnd,
  input  logic [63:0] e_valA,
  input  logic [3:0]  w_icode,
  input  logic [63:0] w_valM,
  input  logic        w_exc,
  output logic [63:0] pc_val,
  output logic        f_stall,
  output logic        d_stall,
  output logic        d_bubble,
  output logic        e_bubble,
  output logic [2:0]  stat,
  output logic        halted,
  output logic [31:0] mispredict_cnt,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] R_NONE  = 4'hF;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  typedef enum logic [2:0] {
    RUN, RET_WAIT, HALT_PEND, ERR_PEND, STOPPED
  } state_t;

  state_t     state;
  logic [2:0] err_code;

  logic load_use, mispredict, ret_res;

  assign load_use   = (e_icode == I_MRMOV || e_icode == I_POP) && (e_dstM != R_NONE) &&
                      (e_dstM == d_srcA || e_dstM == d_srcB);
  assign mispredict = (e_icode == I_JXX) && !e_cnd && (state != STOPPED);
  assign ret_res    = (state == RET_WAIT) && (w_icode == I_RET);
  assign halted     = (state == STOPPED);

  // Controls are forced quiet while reset is asserted so the pipeline
  // registers do not act on a half-initialised sequencer.
  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;
    if (!reset) begin
      if (state == STOPPED) begin
        f_stall = 1'b1;
        d_stall = 1'b1;
      end else if (mispredict) begin
        d_bubble = 1'b1;
        e_bubble = 1'b1;
      end else begin
        if (load_use) begin
          f_stall  = 1'b1;
          d_stall  = 1'b1;
          e_bubble = 1'b1;
        end
        // A load-use stall keeps the decoded instruction in place, so the
        // ret-wait bubble must not overwrite it.
        if (state == RET_WAIT) begin
          f_stall  = 1'b1;
          d_bubble = !load_use;
        end
        if (state == HALT_PEND || state == ERR_PEND) f_stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_val   <= RESET_PC;
      state    <= RUN;
      stat     <= S_AOK;
      err_code <= S_INS;
    end else if (state == STOPPED) begin
      // frozen until reset
    end else if (mispredict) begin
      pc_val <= e_valA;
      state  <= RUN;
    end else if (ret_res) begin
      pc_val <= w_valM;
      state  <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (!load_use) begin
            // A failed fetch makes f_icode meaningless, so errors are
            // examined before the opcode.
            if (f_mem_error) begin
              state    <= ERR_PEND;
              err_code <= S_ADR;
            end else if (!f_valid) begin
              state    <= ERR_PEND;
              err_code <= S_INS;
            end else if (f_icode == I_HALT) begin
              state <= HALT_PEND;
            end else if (f_icode == I_RET) begin
              pc_val <= f_valP;
              state  <= RET_WAIT;
            end else if (f_icode == I_JXX || f_icode == I_CALL) begin
              pc_val <= f_valC;
            end else begin
              pc_val <= f_valP;
            end
          end
        end
        HALT_PEND: if (w_icode == I_HALT) begin
          state <= STOPPED;
          stat  <= S_HLT;
        end
        ERR_PEND: if (w_exc) begin
          state <= STOPPED;
          stat  <= err_code;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] mp_q, st_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      mp_q <= '0;
      st_q <= '0;
    end else begin
      if (mispredict && mp_q != 32'hFFFF_FFFF) mp_q <= mp_q + 32'd1;
      if (f_stall && state != STOPPED && st_q != 32'hFFFF_FFFF) st_q <= st_q + 32'd1;
    end
  end

  assign mispredict_cnt = mp_q;
  assign stall_cnt      = st_q;
`else
  assign mispredict_cnt = 32'd0;
  assign stall_cnt      = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Each step drives inputs on the falling
// edge, pushes the expected controls/PC/status onto a scoreboard queue,
// checks the combinational controls before the rising edge and the
// registered results just after it.

module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  f_icode;
  logic [63:0] f_valC, f_valP;
  logic        f_valid, f_mem_error;
  logic [3:0]  d_srcA, d_srcB;
  logic [3:0]  e_icode, e_dstM;
  logic        e_cnd;
  logic [63:0] e_valA;
  logic [3:0]  w_icode;
  logic [63:0] w_valM;
  logic        w_exc;
  logic [63:0] pc_val;
  logic        f_stall, d_stall, d_bubble, e_bubble;
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] mispredict_cnt, stall_cnt;

  fetch_sequencer #(.RESET_PC(64'd0)) dut (
    .clock(clock), .reset(reset),
    .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .f_valid(f_valid), .f_mem_error(f_mem_error),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .e_icode(e_icode), .e_dstM(e_dstM), .e_cnd(e_cnd), .e_valA(e_valA),
    .w_icode(w_icode), .w_valM(w_valM), .w_exc(w_exc),
    .pc_val(pc_val), .f_stall(f_stall), .d_stall(d_stall),
    .d_bubble(d_bubble), .e_bubble(e_bubble),
    .stat(stat), .halted(halted),
    .mispredict_cnt(mispredict_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [3:0]  ctrl;   // {f_stall, d_stall, d_bubble, e_bubble}
    logic [63:0] pc;
    logic [2:0]  st;
    logic        hl;
    logic [31:0] mc, sc;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_pass = 0;
  int unsigned m_mc = 0, m_sc = 0;
  bit stopped = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    reset = 1'b0; f_icode = 4'h1; f_valC = '0; f_valP = '0;
    f_valid = 1'b1; f_mem_error = 1'b0; d_srcA = 4'hF; d_srcB = 4'hF;
    e_icode = 4'h1; e_dstM = 4'hF; e_cnd = 1'b1; e_valA = '0;
    w_icode = 4'h1; w_valM = '0; w_exc = 1'b0;
  endtask

  // Inputs are already driven; mp marks an expected mispredict this cycle.
  task automatic step(input string tag, input logic [3:0] ctrl, input logic [63:0] pc,
                      input logic [2:0] st, input logic hl, input bit mp);
    exp_t e, g;
    if (reset) begin
      m_mc = 0; m_sc = 0;
    end else begin
      if (mp) m_mc++;
      if (ctrl[3] && !stopped) m_sc++;
    end
    stopped = hl;
    e.tag = tag; e.ctrl = ctrl; e.pc = pc; e.st = st; e.hl = hl;
`ifdef FETCH_SEQ_PERF_EN
    e.mc = m_mc; e.sc = m_sc;
`else
    e.mc = 0; e.sc = 0;
`endif
    sb.push_back(e);
    #1;
    check({tag, ".ctrl"}, {f_stall, d_stall, d_bubble, e_bubble}, sb[0].ctrl);
    @(posedge clock); #1;
    g = sb.pop_front();
    check({g.tag, ".pc"}, pc_val, g.pc);
    check({g.tag, ".stat"}, stat, g.st);
    check({g.tag, ".halted"}, halted, g.hl);
    check({g.tag, ".mcnt"}, mispredict_cnt, g.mc);
    check({g.tag, ".scnt"}, stall_cnt, g.sc);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clock);
    step("reset", 4'b0000, 64'h0, 3'd1, 1'b0, 0);

    // sequential fetch and taken jump
    @(negedge clock); idle(); f_icode = 4'h6; f_valP = 64'h2;
    step("seq", 4'b0000, 64'h2, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); f_icode = 4'h7; f_valC = 64'h10; f_valP = 64'hB;
    step("jmp10", 4'b0000, 64'h10, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); f_icode = 4'h7; f_valC = 64'h40; f_valP = 64'h19;
    step("jmp40", 4'b0000, 64'h40, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); f_icode = 4'h6; f_valP = 64'h4A;
    e_icode = 4'h7; e_cnd = 1'b0; e_valA = 64'h19;
    step("mispred", 4'b0011, 64'h19, 3'd1, 1'b0, 1);

    // load-use via srcA and via srcB; dstM=none never hazards
    @(negedge clock); idle(); f_icode = 4'h6; f_valP = 64'h1B;
    e_icode = 4'h5; e_dstM = 4'h3; d_srcA = 4'h3;
    step("lu_mrmov", 4'b1101, 64'h19, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); f_icode = 4'h6; f_valP = 64'h1B;
    e_icode = 4'hB; e_dstM = 4'h4; d_srcB = 4'h4;
    step("lu_pop", 4'b1101, 64'h19, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); f_icode = 4'h7; f_valC = 64'h20;
    e_icode = 4'h5; e_dstM = 4'hF;
    step("lu_none", 4'b0000, 64'h20, 3'd1, 1'b0, 0);

    // ret and wait for write-back, one wait cycle hit by load-use
    @(negedge clock); idle(); f_icode = 4'h9; f_valP = 64'h22;
    step("ret", 4'b0000, 64'h22, 3'd1, 1'b0, 0);
    @(negedge clock); idle();
    step("rw1", 4'b1010, 64'h22, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); e_icode = 4'h5; e_dstM = 4'h2; d_srcA = 4'h2;
    step("rw_lu", 4'b1101, 64'h22, 3'd1, 1'b0, 0);
    @(negedge clock); idle();
    step("rw3", 4'b1010, 64'h22, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); w_icode = 4'h9; w_valM = 64'h80;
    step("ret_res", 4'b1010, 64'h80, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); f_icode = 4'h6; f_valP = 64'h82;
    step("post_ret", 4'b0000, 64'h82, 3'd1, 1'b0, 0);

    // halt cancelled by mispredict, then a committed halt
    @(negedge clock); idle(); f_icode = 4'h7; f_valC = 64'h30;
    step("jmp30", 4'b0000, 64'h30, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); f_icode = 4'h0; f_valP = 64'h31;
    step("halt_f", 4'b0000, 64'h30, 3'd1, 1'b0, 0);
    @(negedge clock); idle();
    step("halt_p", 4'b1000, 64'h30, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); e_icode = 4'h7; e_cnd = 1'b0; e_valA = 64'h50;
    step("halt_mp", 4'b0011, 64'h50, 3'd1, 1'b0, 1);
    @(negedge clock); idle(); f_icode = 4'h0;
    step("halt_f2", 4'b0000, 64'h50, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); w_icode = 4'h0;
    step("halt_c", 4'b1000, 64'h50, 3'd2, 1'b1, 0);
    @(negedge clock); idle(); f_icode = 4'h7; f_valC = 64'h99;
    e_icode = 4'h7; e_cnd = 1'b0; e_valA = 64'h99;
    step("stopped", 4'b1100, 64'h50, 3'd2, 1'b1, 0);

    // reset out of STOPPED, then reset discarding a pending error
    @(negedge clock); idle(); reset = 1'b1;
    step("rst2", 4'b0000, 64'h0, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); f_icode = 4'h6; f_valP = 64'h60;
    step("seq60", 4'b0000, 64'h60, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); f_mem_error = 1'b1; f_valid = 1'b0;
    step("memerr", 4'b0000, 64'h60, 3'd1, 1'b0, 0);
    @(negedge clock); idle();
    step("err_p", 4'b1000, 64'h60, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); reset = 1'b1; w_exc = 1'b1;
    step("rst_err", 4'b0000, 64'h0, 3'd1, 1'b0, 0);

    // invalid instruction commits as INS
    @(negedge clock); idle(); f_valid = 1'b0;
    step("inv", 4'b0000, 64'h0, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); w_exc = 1'b1;
    step("inv_c", 4'b1000, 64'h0, 3'd4, 1'b1, 0);

    // call to top of memory and unsigned wrap
    @(negedge clock); idle(); reset = 1'b1;
    step("rst3", 4'b0000, 64'h0, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); f_icode = 4'h8; f_valC = 64'hFFFF_FFFF_FFFF_FFFE;
    step("call_top", 4'b0000, 64'hFFFF_FFFF_FFFF_FFFE, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); f_icode = 4'h6; f_valP = 64'h0;
    step("wrap", 4'b0000, 64'h0, 3'd1, 1'b0, 0);

    // memory error wins over invalid and commits as ADR
    @(negedge clock); idle(); f_mem_error = 1'b1; f_valid = 1'b0;
    step("adr", 4'b0000, 64'h0, 3'd1, 1'b0, 0);
    @(negedge clock); idle(); w_exc = 1'b1;
    step("adr_c", 4'b1000, 64'h0, 3'd3, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 64'd0, SHALL be the PC value loaded on reset.
REQ-002 clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 f_icode, f_valC, f_valP, f_valid, f_mem_error  input  4/64/64/1/1  SHALL be the fetch decode of the current pc_val.
REQ-005 d_srcA, d_srcB  input  4/4  SHALL be the decode-stage source register IDs (4'hF = none).
REQ-006 e_icode, e_dstM, e_cnd, e_valA  input  4/4/1/64  SHALL be the execute-stage icode, load destination, branch condition and fall-through PC.
REQ-007 w_icode, w_valM, w_exc  input  4/64/1  SHALL be the write-back icode, the memory value, and the exception-commit flag.
REQ-008 pc_val  output  64  SHALL be the PC presented to fetch.
REQ-009 f_stall, d_stall, d_bubble, e_bubble  output  1 each  SHALL be the pipeline-register controls.
REQ-010 stat  output  3  SHALL be the status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-011 halted  output  1  SHALL be high when the processor has stopped.
REQ-012 mispredict_cnt, stall_cnt  output  32/32  SHALL be the performance counters (see Configuration).

Function
REQ-013 States SHALL be RUN, RET_WAIT, HALT_PEND, ERR_PEND and STOPPED.
REQ-014 In RUN with no hazard, next pc_val SHALL be f_valC for f_icode 7 (jXX) or 8 (call), and f_valP otherwise.
REQ-015 A load-use hazard SHALL occur when e_icode is 5 or 11, e_dstM != 4'hF, and e_dstM equals d_srcA or d_srcB.
REQ-016 On a load-use hazard: pc_val held; f_stall=1, d_stall=1, e_bubble=1, d_bubble=0.
REQ-017 A mispredict SHALL occur when e_icode=7, e_cnd=0 and the state is not STOPPED.
REQ-018 On a mispredict: pc_val<=e_valA; d_bubble=1, e_bubble=1; state<=RUN, cancelling any RET_WAIT, HALT_PEND or ERR_PEND.
REQ-019 Fetching f_icode=9 (ret) in RUN SHALL advance pc_val to f_valP and enter RET_WAIT.
REQ-020 In RET_WAIT: pc_val held, f_stall=1, d_bubble=1 every cycle.
REQ-021 In RET_WAIT, w_icode=9 SHALL load pc_val<=w_valM and return to RUN on the next edge.
REQ-022 Fetching f_icode=0 in RUN SHALL enter HALT_PEND with pc_val held and f_stall=1.
REQ-023 In RUN, f_mem_error=1 or f_valid=0 SHALL enter ERR_PEND with pc_val held and f_stall=1.
REQ-024 In ERR_PEND, the pending code SHALL be latched: 3 for f_mem_error (which has priority over f_valid=0), else 4.
REQ-025 HALT_PEND SHALL enter STOPPED when w_icode=0; ERR_PEND SHALL enter STOPPED when w_exc=1.
REQ-026 Entering STOPPED SHALL set stat to 2 (from HALT_PEND) or to the latched code (from ERR_PEND).
REQ-027 In STOPPED: halted=1, pc_val frozen, f_stall=d_stall=1; only reset exits this state.
REQ-028 Priority SHALL be: reset > mispredict > ret resolution > load-use > new fetch.
REQ-029 When load-use coincides with RET_WAIT, d_stall=1 and d_bubble=0.
REQ-030 All control outputs SHALL be combinational from registered state and inputs; pc_val and stat SHALL be registered.
REQ-031 PC arithmetic SHALL be unsigned 64-bit, and wrap-around SHALL NOT be flagged.

Reset
REQ-032 Reset SHALL set pc_val=RESET_PC, state=RUN, stat=1, halted=0, all stall/bubble outputs=0 and both counters=0.
REQ-033 Reset asserted in any state, including mid-RET_WAIT, SHALL take effect on the next rising edge and discard any pending transition.

Configuration
REQ-034 With FETCH_SEQ_PERF_EN defined, mispredict_cnt SHALL increment per mispredict and stall_cnt per cycle with f_stall=1 outside STOPPED.
REQ-035 With FETCH_SEQ_PERF_EN defined, both counters SHALL saturate at 32'hFFFFFFFF.
REQ-036 Without FETCH_SEQ_PERF_EN, both counters SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-037 Reset with RESET_PC=0; then f_icode=6, f_valP=2 -> pc_val=2 after one edge, stat=1, all controls 0.
REQ-038 f_icode=7, f_valC=0x40 at pc 0x10; next cycle e_icode=7, e_cnd=0, e_valA=0x19 -> pc 0x40 then 0x19, d_bubble=e_bubble=1, mispredict_cnt=1.
REQ-039 e_icode=5, e_dstM=3, d_srcA=3 for one cycle -> pc held, f_stall=d_stall=e_bubble=1, stall_cnt=1.
REQ-040 ret fetched at 0x20 -> RET_WAIT with d_bubble=1; after 3 cycles w_icode=9, w_valM=0x80 -> pc_val=0x80, RUN.
REQ-041 f_icode=0 at 0x30; mispredict before w_icode=0 -> RUN at e_valA; a repeat halt with w_icode=0 -> halted=1, stat=2, pc frozen.
REQ-042 f_mem_error=1 -> ERR_PEND; reset asserted before w_exc -> pc_val=RESET_PC, stat=1, halted=0.
